simd_result_writer: RTL and testbench

SIMD_RESULT_WRITER -- requirements
Module: simd_result_writer

---
 rtl/simd_result_writer.sv | 179 +++++++++++++++++
 tb/tb_simd_result_writer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_result_writer.sv
// -----------------------------------------------------------------------------
// simd_result_writer
//
// Streams a finished DST_H x DST_W image of 8-bit pixels out to a BRAM write
// port, N pixels (lanes) per beat, in raster order starting at BASE_ADDR.
// A beat is presented with wr_valid and is consumed on any cycle where the
// BRAM also raises wr_ready; the beat contents are frozen while it waits.
// The final beat may be partial: lanes that fall past the last pixel are
// disabled and driven to zero.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous, active-high reset
//   start      : level request to begin a write-back pass
//   image_out  : source pixels, image_out[row][col]; must stay stable while busy
//   wr_valid   : a beat is being presented to the BRAM
//   wr_ready   : BRAM accepts the presented beat this cycle
//   wr_en      : per-lane write enable within the beat
//   wr_addr    : per-lane BRAM address (wraps modulo 2^ADDR_BITS)
//   wr_data    : per-lane pixel value
//   busy       : high while in the WRITE state
//   done       : high while in the DONE state
//   beat_cnt   : number of beats accepted since the last start
// -----------------------------------------------------------------------------
module simd_result_writer #(
    parameter int DST_W     = 16,
    parameter int DST_H     = 16,
    parameter int N         = 4,
    parameter int ADDR_BITS = 11,
    parameter int BASE_ADDR = 1024
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [DST_H-1:0][DST_W-1:0][7:0]    image_out,
    output logic                                wr_valid,
    input  logic                                wr_ready,
    output logic [N-1:0]                        wr_en,
    output logic [N-1:0][ADDR_BITS-1:0]         wr_addr,
    output logic [N-1:0][7:0]                   wr_data,
    output logic                                busy,
    output logic                                done,
    output logic [15:0]                         beat_cnt
);

    // Total pixel count and the width of the running pixel index. The index
    // has to hold values up to DEPTH+N-1 so the lane positions of the final,
    // possibly partial, beat never overflow.
    localparam int DEPTH = DST_W * DST_H;
    localparam int IDX_W = $clog2(DEPTH + N + 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } state_t;

    state_t state;

    // Pixel index of lane 0 of the beat currently presented.
    logic [IDX_W-1:0] idx;

    // Packed 2-D image viewed as one flat vector: pixel p = row*DST_W + col
    // sits at bits [p*8 +: 8], which makes the raster-order lookup a simple
    // part-select instead of a divide/modulo by DST_W.
    logic [DEPTH*8-1:0] image_flat;

    assign image_flat = image_out;

    // Lane-0 index of the beat after the current one, and whether the
    // current beat is the last one of the image.
    logic [IDX_W-1:0] idx_step;
    logic             last_beat;

    assign idx_step  = idx + IDX_W'(N);
    assign last_beat = (idx_step >= IDX_W'(DEPTH));

    // Contents of the beat to be loaded into the output registers.
    logic [IDX_W-1:0]            next_idx;
    logic [IDX_W-1:0]            lane_pix;
    logic [N-1:0]                nxt_en;
    logic [N-1:0][ADDR_BITS-1:0] nxt_addr;
    logic [N-1:0][7:0]           nxt_data;

    // Build the next beat. Leaving IDLE always starts from pixel 0; inside
    // WRITE the next beat starts N pixels further on. Lanes beyond the end
    // of the image stay disabled with zero address and data so that a
    // partial tail beat never carries stale values.
    always_comb begin
        next_idx = (state == IDLE) ? '0 : idx_step;
        lane_pix = '0;
        nxt_en   = '0;
        nxt_addr = '0;
        nxt_data = '0;
        for (int k = 0; k < N; k++) begin
            lane_pix = next_idx + IDX_W'(k);
            if (lane_pix < IDX_W'(DEPTH)) begin
                nxt_en[k]   = 1'b1;
                nxt_addr[k] = ADDR_BITS'(BASE_ADDR) + ADDR_BITS'(lane_pix);
                nxt_data[k] = image_flat[{lane_pix, 3'b000} +: 8];
            end
        end
    end

    // Control FSM with every output registered.
    //  IDLE : waits for start; the first beat is loaded on the same edge that
    //         enters WRITE so it is visible in the very first WRITE cycle.
    //  WRITE: presents one beat at a time; a stalled beat simply keeps its
    //         registers, which gives the hold-under-backpressure behaviour for
    //         free. start is not looked at here.
    //  DONE : holds done until start is seen low, so a start line that is
    //         left high cannot trigger an immediate second pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            wr_valid <= 1'b0;
            wr_en    <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= WRITE;
                        idx      <= '0;
                        wr_valid <= 1'b1;
                        wr_en    <= nxt_en;
                        wr_addr  <= nxt_addr;
                        wr_data  <= nxt_data;
                        busy     <= 1'b1;
                        beat_cnt <= '0;
                    end
                end

                WRITE: begin
                    if (wr_valid && wr_ready) begin
                        beat_cnt <= beat_cnt + 16'd1;
                        if (last_beat) begin
                            state    <= DONE;
                            wr_valid <= 1'b0;
                            wr_en    <= '0;
                            wr_addr  <= '0;
                            wr_data  <= '0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            idx     <= idx_step;
                            wr_en   <= nxt_en;
                            wr_addr <= nxt_addr;
                            wr_data <= nxt_data;
                        end
                    end
                end

                DONE: begin
                    if (!start) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    wr_valid <= 1'b0;
                    wr_en    <= '0;
                    wr_addr  <= '0;
                    wr_data  <= '0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simd_result_writer.sv
// -----------------------------------------------------------------------------
// tb_simd_result_writer
//
// Drives three instances of simd_result_writer: the default 16x16 / 4-lane
// configuration, a 5x3 image whose last beat is partial, and an 8-bit address
// space starting at 254 so the addresses wrap. Expected beats come from a
// raster-order reference model computed from the pixel arrays kept here.
// -----------------------------------------------------------------------------
module tb_simd_result_writer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Default configuration
    logic                   start0, ready0;
    logic [15:0][15:0][7:0] img0;
    logic                   valid0, busy0, done0;
    logic [3:0]             en0;
    logic [3:0][10:0]       addr0;
    logic [3:0][7:0]        data0;
    logic [15:0]            cnt0;

    // 5x3 image, partial tail beat
    logic                   start1, ready1;
    logic [2:0][4:0][7:0]   img1;
    logic                   valid1, busy1, done1;
    logic [3:0]             en1;
    logic [3:0][10:0]       addr1;
    logic [3:0][7:0]        data1;
    logic [15:0]            cnt1;

    // 8-bit address space, base 254, shares the default image
    logic                   start2, ready2;
    logic                   valid2, busy2, done2;
    logic [3:0]             en2;
    logic [3:0][7:0]        addr2;
    logic [3:0][7:0]        data2;
    logic [15:0]            cnt2;

    int pix0 [256];
    int pix1 [15];
    int passCount  = 0;
    int totalCount = 0;

    simd_result_writer dut0 (
        .clk(clk), .rst(rst), .start(start0), .image_out(img0),
        .wr_valid(valid0), .wr_ready(ready0), .wr_en(en0), .wr_addr(addr0),
        .wr_data(data0), .busy(busy0), .done(done0), .beat_cnt(cnt0)
    );

    simd_result_writer #(.DST_W(5), .DST_H(3), .N(4)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .image_out(img1),
        .wr_valid(valid1), .wr_ready(ready1), .wr_en(en1), .wr_addr(addr1),
        .wr_data(data1), .busy(busy1), .done(done1), .beat_cnt(cnt1)
    );

    simd_result_writer #(.ADDR_BITS(8), .BASE_ADDR(254)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .image_out(img0),
        .wr_valid(valid2), .wr_ready(ready2), .wr_en(en2), .wr_addr(addr2),
        .wr_data(data2), .busy(busy2), .done(done2), .beat_cnt(cnt2)
    );

    // Reference model: configuration w, beat b covers pixels b*4 .. b*4+3
    function automatic int depthOf(input int w);
        return (w == 1) ? 15 : 256;
    endfunction

    function automatic int baseOf(input int w);
        return (w == 2) ? 254 : 1024;
    endfunction

    function automatic int abitsOf(input int w);
        return (w == 2) ? 8 : 11;
    endfunction

    function automatic logic [3:0] expEn(input int w, input int b);
        logic [3:0] r;
        r = '0;
        for (int k = 0; k < 4; k++)
            r[k] = ((b * 4 + k) < depthOf(w));
        return r;
    endfunction

    function automatic logic [63:0] expAddr(input int w, input int b);
        logic [63:0] r;
        int p;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            p = b * 4 + k;
            if (p < depthOf(w))
                r = r | (64'((baseOf(w) + p) % (1 << abitsOf(w))) << (k * abitsOf(w)));
        end
        return r;
    endfunction

    function automatic logic [63:0] expData(input int w, input int b);
        logic [63:0] r;
        int p;
        int v;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            p = b * 4 + k;
            if (p < depthOf(w)) begin
                v = (w == 1) ? pix1[p] : pix0[p];
                r = r | (64'(v & 255) << (k * 8));
            end
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        totalCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic r);
        start0 = s;
        ready0 = r;
    endtask

    // pattern=1 gives pixel (r,c) = r*16+c, otherwise random bytes
    task automatic setImage0(input bit pattern);
        for (int p = 0; p < 256; p++) begin
            pix0[p] = pattern ? p : int'($urandom_range(0, 255));
            img0[p / 16][p % 16] = 8'(pix0[p]);
        end
    endtask

    // One full pass on dut0. mode 0: ready always high, mode 1: three stall
    // cycles on beat 5, mode 2: random ready. randStart toggles start during
    // WRITE, holdStart keeps it high for the whole pass.
    task automatic runDefault(input int mode, input bit holdStart, input bit randStart);
        int  b;
        int  stall;
        int  cycles;
        logic r;
        applyStimulus(1'b1, 1'b0);
        step();
        start0 = holdStart;
        b = 0;
        stall = 0;
        cycles = 0;
        while (b < 64 && cycles < 1000) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = !(b == 5 && stall < 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            if (mode == 1 && b == 5 && !r) stall++;
            ready0 = r;
            if (randStart) start0 = 1'($urandom_range(0, 1));
            checkOutput("run_valid", 64'(valid0), 64'd1);
            checkOutput("run_busy", 64'(busy0), 64'd1);
            checkOutput("run_cnt", 64'(cnt0), 64'(b));
            checkOutput("run_en", 64'(en0), 64'(expEn(0, b)));
            checkOutput("run_addr", 64'(addr0), expAddr(0, b));
            checkOutput("run_data", 64'(data0), expData(0, b));
            if (r) b++;
            step();
            cycles++;
        end
        checkOutput("run_complete", 64'(b), 64'd64);
        if (mode == 0) checkOutput("run_cycles", 64'(cycles), 64'd64);
        if (mode == 1) checkOutput("run_cycles_stall", 64'(cycles), 64'd67);
        ready0 = 1'b0;
        checkOutput("end_valid", 64'(valid0), 64'd0);
        checkOutput("end_en", 64'(en0), 64'd0);
        checkOutput("end_busy", 64'(busy0), 64'd0);
        checkOutput("end_done", 64'(done0), 64'd1);
        checkOutput("end_cnt", 64'(cnt0), 64'd64);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        start1 = 1'b0; ready1 = 1'b0;
        start2 = 1'b0; ready2 = 1'b0;
        setImage0(1'b1);
        for (int p = 0; p < 15; p++) begin
            pix1[p] = int'($urandom_range(0, 255));
            img1[p / 5][p % 5] = 8'(pix1[p]);
        end

        // Reset state, before any clock edge
        #2;
        checkOutput("rst_valid", 64'(valid0), 64'd0);
        checkOutput("rst_en", 64'(en0), 64'd0);
        checkOutput("rst_addr", 64'(addr0), 64'd0);
        checkOutput("rst_data", 64'(data0), 64'd0);
        checkOutput("rst_busy", 64'(busy0), 64'd0);
        checkOutput("rst_done", 64'(done0), 64'd0);
        checkOutput("rst_cnt", 64'(cnt0), 64'd0);
        step();
        step();
        rst = 1'b0;

        // wr_ready toggling while idle does nothing
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 1)));
            step();
            checkOutput("idle_valid", 64'(valid0), 64'd0);
            checkOutput("idle_cnt", 64'(cnt0), 64'd0);
        end

        // Ramp image, full-rate pass, then back to IDLE with count held
        runDefault(0, 1'b0, 1'b0);
        start0 = 1'b0;
        step();
        checkOutput("idle_done", 64'(done0), 64'd0);
        checkOutput("idle_cnt_hold", 64'(cnt0), 64'd64);

        // Three-cycle stall on beat 5
        runDefault(1, 1'b0, 1'b0);
        start0 = 1'b0;
        step();

        // Random image, random ready, start wiggling during WRITE
        setImage0(1'b0);
        runDefault(2, 1'b0, 1'b1);
        start0 = 1'b0;
        step();
        checkOutput("rand_idle_done", 64'(done0), 64'd0);

        // start held high through DONE must not restart
        runDefault(0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("hold_done", 64'(done0), 64'd1);
            checkOutput("hold_valid", 64'(valid0), 64'd0);
            checkOutput("hold_cnt", 64'(cnt0), 64'd64);
        end
        start0 = 1'b0;
        step();
        checkOutput("hold_release", 64'(done0), 64'd0);
        runDefault(0, 1'b0, 1'b0);
        start0 = 1'b0;
        step();

        // Asynchronous reset while beat 10 is presented
        applyStimulus(1'b1, 1'b1);
        step();
        start0 = 1'b0;
        for (int i = 0; i < 10; i++) step();
        checkOutput("pre_rst_cnt", 64'(cnt0), 64'd10);
        checkOutput("pre_rst_addr", 64'(addr0), expAddr(0, 10));
        #3 rst = 1'b1;
        #1;
        checkOutput("arst_valid", 64'(valid0), 64'd0);
        checkOutput("arst_en", 64'(en0), 64'd0);
        checkOutput("arst_addr", 64'(addr0), 64'd0);
        checkOutput("arst_data", 64'(data0), 64'd0);
        checkOutput("arst_busy", 64'(busy0), 64'd0);
        checkOutput("arst_cnt", 64'(cnt0), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("post_rst_valid", 64'(valid0), 64'd0);
            checkOutput("post_rst_cnt", 64'(cnt0), 64'd0);
        end
        runDefault(0, 1'b0, 1'b0);
        start0 = 1'b0;

        // 5x3 image: four beats, last one partial
        start1 = 1'b1;
        ready1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int b = 0; b < 4; b++) begin
            checkOutput("tail_valid", 64'(valid1), 64'd1);
            checkOutput("tail_en", 64'(en1), 64'(expEn(1, b)));
            checkOutput("tail_addr", 64'(addr1), expAddr(1, b));
            checkOutput("tail_data", 64'(data1), expData(1, b));
            if (b == 3) checkOutput("tail_last_en", 64'(en1), 64'b0111);
            step();
        end
        checkOutput("tail_done", 64'(done1), 64'd1);
        checkOutput("tail_busy", 64'(busy1), 64'd0);
        checkOutput("tail_valid_end", 64'(valid1), 64'd0);
        checkOutput("tail_cnt", 64'(cnt1), 64'd4);

        // 8-bit address space starting at 254
        start2 = 1'b1;
        ready2 = 1'b1;
        step();
        start2 = 1'b0;
        checkOutput("wrap_beat0", 64'(addr2), 64'h0100FFFE);
        for (int b = 0; b < 64; b++) begin
            checkOutput("wrap_en", 64'(en2), 64'(expEn(2, b)));
            checkOutput("wrap_addr", 64'(addr2), expAddr(2, b));
            checkOutput("wrap_data", 64'(data2), expData(2, b));
            step();
        end
        checkOutput("wrap_done", 64'(done2), 64'd1);
        checkOutput("wrap_busy", 64'(busy2), 64'd0);
        checkOutput("wrap_valid_end", 64'(valid2), 64'd0);
        checkOutput("wrap_cnt", 64'(cnt2), 64'd64);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
